// File: rtl/auto_player.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : auto_player
// Purpose  : Watches the memory game's sequence LEDs, records each symbol and
//            replays them as timed one-hot key presses when play_led rises.
// Revision : 1.0 - initial release
// ============================================================================

module auto_player #(
    parameter int MAX_LEN      = 100,
    parameter int DWELL        = 32,
    parameter int PRESS_CYCLES = 8,
    parameter int GAP_CYCLES   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       play_led,
    input  logic [3:0] key_leds,
    output logic [3:0] keys_out,
    output logic [7:0] seq_len,
    output logic       busy,
    output logic       overflow
);

    localparam int c_AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int c_DW   = (DWELL > 2) ? $clog2(DWELL) : 1;
    localparam int c_TMAX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
    localparam int c_TW   = (c_TMAX > 2) ? $clog2(c_TMAX) : 1;

    localparam logic [7:0]      c_MAX        = 8'(MAX_LEN);
    localparam logic [c_DW-1:0] c_DWELL_LAST = c_DW'(DWELL - 1);
    localparam logic [c_TW-1:0] c_PRESS_LAST = c_TW'(PRESS_CYCLES - 1);
    localparam logic [c_TW-1:0] c_GAP_LAST   = c_TW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_PRESS   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t          r_state,    w_state;
    logic [3:0]      r_keys,     w_keys;
    logic [7:0]      r_seq_len,  w_seq_len;
    logic            r_overflow, w_overflow;
    logic [c_DW-1:0] r_dwell,    w_dwell;
    logic [7:0]      r_index,    w_index;
    logic [c_TW-1:0] r_timer,    w_timer;
    logic [3:0]      r_prev_leds;
    logic            r_play_d;
    logic [1:0]      r_buf [0:MAX_LEN-1];

    logic            w_onehot, w_same, w_sample, w_rise, w_full;
    logic            w_wr_en, w_fwd;
    logic [1:0]      w_sym, w_press_sym;

    assign w_onehot = (key_leds == 4'b0001) || (key_leds == 4'b0010) ||
                      (key_leds == 4'b0100) || (key_leds == 4'b1000);
    assign w_same   = w_onehot && (key_leds == r_prev_leds);
    // The rising-edge cycle still samples, so a symbol completing then is kept.
    assign w_sample = ~play_led | ~r_play_d;
    assign w_rise   = play_led & ~r_play_d;
    assign w_full   = (r_seq_len == c_MAX);

    always_comb begin
        w_sym = 2'd0;
        case (key_leds)
            4'b0010: w_sym = 2'd1;
            4'b0100: w_sym = 2'd2;
            4'b1000: w_sym = 2'd3;
            default: w_sym = 2'd0;
        endcase
    end

    always_comb begin
        w_state    = r_state;
        w_seq_len  = r_seq_len;
        w_overflow = r_overflow;
        w_dwell    = '0;
        w_index    = r_index;
        w_timer    = r_timer;
        w_wr_en    = 1'b0;
        w_fwd      = 1'b0;

        if (!enable) begin
            w_state   = ST_IDLE;
            w_seq_len = 8'd0;
            w_index   = 8'd0;
            w_timer   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state    = ST_CAPTURE;
                    w_seq_len  = 8'd0;
                    w_overflow = 1'b0;
                end
                ST_CAPTURE: begin
                    if (w_sample && w_onehot) begin
                        // Counter holds cycles seen so far, so a fresh value starts at 1
                        // and a steady LED yields exactly one symbol per DWELL cycles.
                        if (w_same && (r_dwell == c_DWELL_LAST)) begin
                            if (w_full) begin
                                w_overflow = 1'b1;
                            end else begin
                                w_wr_en   = 1'b1;
                                w_seq_len = r_seq_len + 8'd1;
                            end
                        end else if (w_same) begin
                            w_dwell = r_dwell + c_DW'(1);
                        end else begin
                            w_dwell = c_DW'(1);
                        end
                    end
                    if (w_rise) begin
                        w_index = 8'd0;
                        w_timer = '0;
                        w_dwell = '0;
                        if (w_seq_len != 8'd0) begin
                            w_state = ST_PRESS;
                            w_fwd   = (r_seq_len == 8'd0);
                        end else begin
                            w_state = ST_DONE;
                        end
                    end
                end
                ST_PRESS, ST_RELEASE: begin
                    if (!play_led) begin
                        w_state   = ST_CAPTURE;
                        w_seq_len = 8'd0;
                        w_index   = 8'd0;
                        w_timer   = '0;
                    end else if (r_state == ST_PRESS) begin
                        if (r_timer == c_PRESS_LAST) begin
                            w_state = ST_RELEASE;
                            w_timer = '0;
                        end else begin
                            w_timer = r_timer + c_TW'(1);
                        end
                    end else if (r_timer == c_GAP_LAST) begin
                        w_timer = '0;
                        w_index = r_index + 8'd1;
                        w_state = ((r_index + 8'd1) == r_seq_len) ? ST_DONE : ST_PRESS;
                    end else begin
                        w_timer = r_timer + c_TW'(1);
                    end
                end
                ST_DONE: begin
                    if (!play_led) begin
                        w_state   = ST_CAPTURE;
                        w_seq_len = 8'd0;
                    end
                end
                default: w_state = ST_IDLE;
            endcase
        end

        w_press_sym = w_fwd ? w_sym : r_buf[w_index[c_AW-1:0]];
        w_keys      = (w_state == ST_PRESS) ? (4'b0001 << w_press_sym) : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_keys      <= 4'b0000;
            r_seq_len   <= 8'd0;
            r_overflow  <= 1'b0;
            r_dwell     <= '0;
            r_index     <= 8'd0;
            r_timer     <= '0;
            r_prev_leds <= 4'b0000;
            r_play_d    <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_keys      <= w_keys;
            r_seq_len   <= w_seq_len;
            r_overflow  <= w_overflow;
            r_dwell     <= w_dwell;
            r_index     <= w_index;
            r_timer     <= w_timer;
            r_prev_leds <= key_leds;
            r_play_d    <= play_led;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf[r_seq_len[c_AW-1:0]] <= w_sym;
        end
    end

    assign keys_out = r_keys;
    assign seq_len  = r_seq_len;
    assign overflow = r_overflow;
    assign busy     = (r_state == ST_PRESS) || (r_state == ST_RELEASE);

endmodule

`default_nettype wire
